alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 139 +++++++++++++
 tb/tb_alu_result_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// A small FIFO that buffers results from an 8-bit adder/subtractor stage. Each
// entry holds the two's-complement result and its signed-overflow flag. A
// sticky flag records that at least one accepted entry overflowed.
//
// Optional feature (compile-time macro):
//   ALU_RESULT_SAT_EN - when defined, an entry pushed with in_ovf=1 is stored
//                       saturated (8'h7F if in_s[7]=1, 8'h80 if in_s[7]=0).
//                       When undefined, in_s is stored unmodified.
//
// Parameters:
//   DEPTH      number of entries; power of two, 2..16
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream result valid this cycle
//   in_ready   FIFO can accept a result this cycle (also true when full if a
//              pop happens in the same cycle)
//   in_s       8-bit upstream sum/difference
//   in_ovf     upstream signed-overflow flag for in_s
//   out_valid  head entry available (count != 0)
//   out_ready  downstream accepts the head entry this cycle
//   out_data   head entry result
//   out_ovf    head entry overflow flag
//   count      current occupancy, 0..DEPTH
//   ovf_sticky set after any accepted entry with in_ovf=1
//   clr_sticky clears ovf_sticky (a same-cycle overflow push wins)
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_s,
    input  logic                       in_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_sticky,
    input  logic                       clr_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [7:0]    mem_data [DEPTH];
    logic          mem_ovf  [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic          push;
    logic          pop;
    logic [7:0]    store_s;

    // Handshake: a full FIFO still accepts when the head leaves this cycle.
    // out_valid depends only on registered occupancy, so a push is never
    // visible downstream before the following cycle.
    always_comb begin
        out_valid = (cnt != '0);
        in_ready  = (cnt < FULL_CNT) || out_ready;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

`ifdef ALU_RESULT_SAT_EN
    // On overflow the sign bit of the wrapped result is the opposite of the
    // true sign, so a set sign bit means a positive overflow and vice versa.
    always_comb begin
        store_s = in_s;
        if (in_ovf) begin
            store_s = in_s[7] ? 8'h7F : 8'h80;
        end
    end
`else
    always_comb begin
        store_s = in_s;
    end
`endif

    // Storage array is intentionally not reset; its contents are only
    // observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_data[wr_ptr] <= store_s;
            mem_ovf[wr_ptr]  <= in_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A new overflow takes priority over a same-cycle clear so that the
    // event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (push && in_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

    always_comb begin
        out_data = mem_data[rd_ptr];
        out_ovf  = mem_ovf[rd_ptr];
        count    = cnt;
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_s;
    logic          in_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_ovf;
    logic [CW-1:0] count;
    logic          ovf_sticky;
    logic          clr_sticky;

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of {ovf, data} entries plus the sticky bit.
    logic [8:0] model_q[$];
    logic       model_sticky;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] stored_value(input logic [7:0] s, input logic ovf);
`ifdef ALU_RESULT_SAT_EN
        if (ovf) return s[7] ? 8'h7F : 8'h80;
`endif
        return s;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model before
    // the edge, then advance the model by the rules of the handshake.
    task automatic cycle(input logic v, input logic [7:0] s, input logic o,
                         input logic rdy, input logic clr, input logic r);
        bit m_push;
        bit m_pop;
        in_valid   = v;
        in_s       = s;
        in_ovf     = o;
        out_ready  = rdy;
        clr_sticky = clr;
        rst        = r;
        #1;
        chk("count", 32'(count), 32'(model_q.size()));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'((model_q.size() < DEPTH) || rdy));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(model_sticky));
        if (model_q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(model_q[0][7:0]));
            chk("out_ovf", 32'(out_ovf), 32'(model_q[0][8]));
        end
        if (r) begin
            model_q.delete();
            model_sticky = 1'b0;
        end else begin
            m_push = v && ((model_q.size() < DEPTH) || rdy);
            m_pop  = (model_q.size() != 0) && rdy;
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back({o, stored_value(s, o)});
            if (m_push && o) model_sticky = 1'b1;
            else if (clr) model_sticky = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid = 0; in_s = 0; in_ovf = 0; out_ready = 0; clr_sticky = 0; rst = 1;
        model_sticky = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;

        // reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sticky", 32'(ovf_sticky), 0);

        // ordered push then pop
        cycle(1, 8'h05, 0, 0, 0, 0);
        cycle(1, 8'h0A, 0, 0, 0, 0);
        cycle(1, 8'hFF, 0, 0, 0, 0);
        chk("basic_count3", 32'(count), 3);
        chk("basic_head", 32'(out_data), 32'h05);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1, 0, 0);
        chk("basic_count0", 32'(count), 0);

        // full: blocked push, then push+pop on full
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8'h33, 0, 0, 0, 0);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_count", 32'(count), DEPTH);
        cycle(1, 8'h33, 0, 1, 0, 0);
        chk("full_pp_count", 32'(count), DEPTH);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 8'h00, 0, 1, 0, 0);
        out_ready = 0;
        #1;
        chk("full_33_head", 32'(out_data), 32'h33);
        @(negedge clk);
        drain();

        // positive overflow
        cycle(1, 8'h80, 1, 0, 0, 0);
        chk("ovf_sticky_set", 32'(ovf_sticky), 1);
        chk("ovf_out_ovf", 32'(out_ovf), 1);
`ifdef ALU_RESULT_SAT_EN
        chk("ovf_pos_data", 32'(out_data), 32'h7F);
`else
        chk("ovf_pos_data", 32'(out_data), 32'h80);
`endif
        drain();
        chk("pop_keeps_sticky", 32'(ovf_sticky), 1);

        // negative overflow, clear vs set priority
        cycle(1, 8'h7F, 1, 0, 0, 0);
`ifdef ALU_RESULT_SAT_EN
        chk("ovf_neg_data", 32'(out_data), 32'h80);
`else
        chk("ovf_neg_data", 32'(out_data), 32'h7F);
`endif
        drain();
        cycle(1, 8'h11, 1, 1, 1, 0);
        chk("clr_vs_set", 32'(ovf_sticky), 1);
        cycle(0, 8'h00, 0, 1, 1, 0);
        chk("clr_alone", 32'(ovf_sticky), 0);
        drain();

        // wrap through the pointers with continuous push/pop
        for (int i = 0; i < 10; i++) cycle(1, 8'(i), 0, 1, 0, 0);
        chk("wrap_count", 32'(count), 1);
        chk("wrap_last", 32'(out_data), 32'h09);
        drain();

        // reset mid-operation
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'hA0 + i), 1, 0, 0, 0);
        cycle(1, 8'h55, 1, 1, 0, 1);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_sticky", 32'(ovf_sticky), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        cycle(1, 8'h42, 0, 0, 0, 0);
        chk("midrst_push42", 32'(out_data), 32'h42);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  8'($urandom),
                  1'($urandom_range(0, 99) < 15),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 10),
                  1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
